// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port asynchronous SRAM arbiter.
// SRAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority in sram_arb_pick.
package sram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    typedef logic port_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_arb_pick.sv
// Two-way winner select: round-robin, or fixed port-0 priority when
// SRAM_ARB_FIXED_PRIO_EN is defined.
module sram_arb_pick
    import sram_arb_pkg::*;
(
`ifndef SRAM_ARB_FIXED_PRIO_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
`endif
    input  logic [1:0] req,
    output port_t      win
);

`ifdef SRAM_ARB_FIXED_PRIO_EN

    assign win = req[0] ? 1'b0 : req[1];

`else

    port_t last_q;

    // Tie goes to the port that was not granted last.
    assign win = (&req) ? ~last_q : req[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (adv) begin
            last_q <= win;
        end
    end

`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for a 16-bit asynchronous SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int ACC_CYC = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_be,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_be,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    inout  wire  [DATA_W-1:0] sram_DQ,
    output logic [ADDR_W-1:0] sram_ADDR,
    output logic              sram_LB_N,
    output logic              sram_UB_N,
    output logic              sram_CE_N,
    output logic              sram_OE_N,
    output logic              sram_WE_N
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        req;
    logic              grant;
    logic              done;
    port_t             win, port_q;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        be_q;

    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [1:0]        cmd_be;

    logic              nxt_we;
    logic [1:0]        nxt_be;
    logic              ce_d, oe_d, we_d, lb_d, ub_d, dq_oe_d;
    logic              dq_oe_q;
    logic [1:0]        ack_q, rvalid_q;

    assign req   = {p1_req, p0_req};
    assign grant = (state_q == IDLE) && (|req);
    assign done  = (state_q == ACC) && (cnt_q == '0);

    sram_arb_pick u_pick (
`ifndef SRAM_ARB_FIXED_PRIO_EN
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .adv   (grant),
`endif
        .req   (req),
        .win   (win)
    );

    assign cmd_we    = win ? p1_we    : p0_we;
    assign cmd_addr  = win ? p1_addr  : p0_addr;
    assign cmd_wdata = win ? p1_wdata : p0_wdata;
    assign cmd_be    = win ? p1_be    : p0_be;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = ACC;
            ACC:     if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next pin values; WE_N stays high on the first ACC cycle for setup.
    always_comb begin
        nxt_we  = grant ? cmd_we : we_q;
        nxt_be  = grant ? cmd_be : be_q;
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        lb_d    = 1'b1;
        ub_d    = 1'b1;
        dq_oe_d = 1'b0;
        if (state_d == ACC) begin
            ce_d = 1'b0;
            lb_d = ~nxt_be[0];
            ub_d = ~nxt_be[1];
            if (nxt_we) begin
                dq_oe_d = 1'b1;
                we_d    = grant;
            end else begin
                oe_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q     <= '0;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            sram_CE_N <= 1'b1;
            sram_OE_N <= 1'b1;
            sram_WE_N <= 1'b1;
            sram_LB_N <= 1'b1;
            sram_UB_N <= 1'b1;
            dq_oe_q   <= 1'b0;
            ack_q     <= '0;
            rvalid_q  <= '0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            ack_q     <= '0;
            rvalid_q  <= '0;
            sram_CE_N <= ce_d;
            sram_OE_N <= oe_d;
            sram_WE_N <= we_d;
            sram_LB_N <= lb_d;
            sram_UB_N <= ub_d;
            dq_oe_q   <= dq_oe_d;
            if (grant) begin
                port_q     <= win;
                we_q       <= cmd_we;
                addr_q     <= cmd_addr;
                wdata_q    <= cmd_wdata;
                be_q       <= cmd_be;
                cnt_q      <= CNT_W'(ACC_CYC - 1);
                ack_q[win] <= 1'b1;
            end else if (state_q == ACC) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (done && !we_q) begin
                rvalid_q[port_q] <= 1'b1;
                if (port_q) p1_rdata <= sram_DQ;
                else        p0_rdata <= sram_DQ;
            end
        end
    end

    assign sram_DQ   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign sram_ADDR = addr_q;
    assign p0_ack    = ack_q[0];
    assign p1_ack    = ack_q[1];
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM pin model, transaction-level reference
// model with per-cycle compare, directed and randomized stimulus.
module tb_sram_arbiter;

    localparam int ACC  = 2;
    localparam int MAXC = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req [2];
    logic        we [2];
    logic [19:0] addr [2];
    logic [15:0] wd [2];
    logic [1:0]  be [2];

    logic        ack0, ack1, rv0, rv1;
    logic [15:0] rd0, rd1;
    wire  [15:0] dq;
    logic [19:0] sa;
    logic        lb_n, ub_n, ce_n, oe_n, we_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #10 clk = ~clk;

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACC_CYC(ACC)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]),
        .p0_wdata(wd[0]), .p0_be(be[0]), .p0_ack(ack0),
        .p0_rdata(rd0), .p0_rvalid(rv0),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]),
        .p1_wdata(wd[1]), .p1_be(be[1]), .p1_ack(ack1),
        .p1_rdata(rd1), .p1_rvalid(rv1),
        .sram_DQ(dq), .sram_ADDR(sa),
        .sram_LB_N(lb_n), .sram_UB_N(ub_n), .sram_CE_N(ce_n),
        .sram_OE_N(oe_n), .sram_WE_N(we_n)
    );

    function automatic logic [15:0] init_val(logic [19:0] a);
        return a[15:0] ^ 16'h5a5a;
    endfunction

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
        end
    endfunction

    // SRAM device model
    logic [15:0] smem [logic [19:0]];
    logic [15:0] s_rd = 16'h0;

    always @(negedge clk) begin
        logic [15:0] w;
        if (!ce_n && !we_n) begin
            w = smem.exists(sa) ? smem[sa] : init_val(sa);
            if (!lb_n) w[7:0] = dq[7:0];
            if (!ub_n) w[15:8] = dq[15:8];
            smem[sa] = w;
        end
        s_rd = smem.exists(sa) ? smem[sa] : init_val(sa);
    end

    assign dq = (!ce_n && !oe_n && we_n) ? s_rd : 16'hzzzz;

    // Reference model: per-cycle expectations from granted transactions
    logic [15:0] rmem [logic [19:0]];
    bit          e_ack [2][MAXC];
    bit          e_rv  [2][MAXC];
    logic [15:0] e_rd  [2][MAXC];
    bit          e_ce  [MAXC];
    bit          e_oe  [MAXC];
    bit          e_wen [MAXC];
    bit          e_lb  [MAXC];
    bit          e_ub  [MAXC];
    bit          e_dq  [MAXC];
    logic [15:0] e_dqv [MAXC];
    logic [19:0] e_adr [MAXC];
    int          free_at = 0;
    int          last = 1;
    logic [15:0] hold [2];

    always @(posedge clk or negedge rst_n) begin
        int w;
        logic [15:0] v;
        if (!rst_n) begin
            for (int i = 0; i < MAXC; i++) begin
                for (int p = 0; p < 2; p++) begin
                    e_ack[p][i] = 0;
                    e_rv[p][i]  = 0;
                end
                e_ce[i] = 0; e_oe[i] = 0; e_wen[i] = 0;
                e_dq[i] = 0;
            end
            free_at = 0;
            last = 1;
        end else begin
            if (cyc >= free_at && (req[0] || req[1])
                && cyc + ACC + 1 < MAXC) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                w = req[0] ? 0 : 1;
`else
                if (req[0] && req[1]) w = 1 - last;
                else w = req[0] ? 0 : 1;
                last = w;
`endif
                v = rmem.exists(addr[w]) ? rmem[addr[w]] : init_val(addr[w]);
                e_ack[w][cyc+1] = 1;
                for (int k = 1; k <= ACC; k++) begin
                    e_ce[cyc+k]  = 1;
                    e_adr[cyc+k] = addr[w];
                    e_lb[cyc+k]  = be[w][0];
                    e_ub[cyc+k]  = be[w][1];
                    if (we[w]) begin
                        e_dq[cyc+k]  = 1;
                        e_dqv[cyc+k] = wd[w];
                        e_wen[cyc+k] = (k >= 2);
                    end else begin
                        e_oe[cyc+k] = 1;
                    end
                end
                if (we[w]) begin
                    if (be[w][0]) v[7:0] = wd[w][7:0];
                    if (be[w][1]) v[15:8] = wd[w][15:8];
                    rmem[addr[w]] = v;
                end else begin
                    e_rv[w][cyc+ACC+1] = 1;
                    e_rd[w][cyc+ACC+1] = v;
                end
                free_at = cyc + ACC + 1;
            end
            cyc++;
        end
    end

    // Per-cycle compare of DUT outputs against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            hold[0] = 16'h0;
            hold[1] = 16'h0;
        end
        if (cyc < MAXC) begin
            for (int p = 0; p < 2; p++)
                if (e_rv[p][cyc]) hold[p] = e_rd[p][cyc];
            chk("ack0", ack0, e_ack[0][cyc]);
            chk("ack1", ack1, e_ack[1][cyc]);
            chk("rvalid0", rv0, e_rv[0][cyc]);
            chk("rvalid1", rv1, e_rv[1][cyc]);
            chk("rdata0", rd0, hold[0]);
            chk("rdata1", rd1, hold[1]);
            chk("ce_n", ce_n, !e_ce[cyc]);
            chk("oe_n", oe_n, !e_oe[cyc]);
            chk("we_n", we_n, !e_wen[cyc]);
            if (e_ce[cyc]) begin
                chk("lb_n", lb_n, !e_lb[cyc]);
                chk("ub_n", ub_n, !e_ub[cyc]);
                chk("addr", sa, e_adr[cyc]);
            end else begin
                chk("lb_n_idle", lb_n, 1);
                chk("ub_n_idle", ub_n, 1);
            end
            if (e_dq[cyc]) chk("dq_wdata", dq, e_dqv[cyc]);
        end
    end

    task automatic issue(input int p, input bit w, input logic [19:0] a,
                         input logic [15:0] d, input logic [1:0] b,
                         output int t);
        int n;
        @(negedge clk);
        we[p] = w; addr[p] = a; wd[p] = d; be[p] = b;
        req[p] = 1'b1;
        t = -1;
        n = 0;
        while (t < 0 && n < 200) begin
            @(negedge clk);
            if ((p == 0 && ack0) || (p == 1 && ack1)) t = cyc;
            n++;
        end
        req[p] = 1'b0;
        if (t < 0) chk("ack_timeout", 0, 1);
    endtask

    task automatic rand_port(input int p, input int num);
        int t;
        for (int i = 0; i < num; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(p, (p == 0) ? ($urandom_range(0, 3) == 0)
                              : bit'($urandom_range(0, 1)),
                  20'($urandom_range(0, 31)), 16'($urandom),
                  2'($urandom_range(0, 3)), t);
        end
    endtask

    initial begin
        int t, t0 [3], t1 [3];
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t0 [3];
        int t1 [3];
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 0; we[p] = 0; addr[p] = 0; wd[p] = 0; be[p] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ce_n", ce_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_we_n", we_n, 1);
        chk("rst_addr", sa, 0);
        chk("rst_acks", {ack0, ack1, rv0, rv1}, 0);
        chk("rst_rdata", {rd0, rd1}, 0);
        rst_n = 1'b1;

        issue(1, 1, 20'h00123, 16'hA5C3, 2'b11, t);
        chk("t1_ce_acc1", ce_n, 0);
        chk("t1_we_acc1", we_n, 1);
        for (int k = 2; k <= ACC; k++) begin
            @(negedge clk);
            chk("t1_we_acck", we_n, 0);
        end
        @(negedge clk);
        chk("t1_we_idle", we_n, 1);
        chk("t1_ce_idle", ce_n, 1);
        issue(1, 0, 20'h00123, 16'h0, 2'b11, t);
        repeat (ACC) @(negedge clk);
        chk("t1_rvalid", rv1, 1);
        chk("t1_rdata", rd1, 16'hA5C3);

        issue(1, 1, 20'h00010, 16'hFFFF, 2'b11, t);
        issue(1, 1, 20'h00010, 16'h1200, 2'b10, t);
        chk("bw_lb_n", lb_n, 1);
        chk("bw_ub_n", ub_n, 0);
        issue(1, 0, 20'h00010, 16'h0, 2'b11, t);
        repeat (ACC) @(negedge clk);
        chk("bw_rdata", rd1, 16'h12FF);

        fork
            for (int i = 0; i < 3; i++)
                issue(0, 0, 20'h00010, 16'h0, 2'b11, t0[i]);
            for (int i = 0; i < 3; i++)
                issue(1, 0, 20'h00123, 16'h0, 2'b11, t1[i]);
        join
        for (int i = 0; i < 3; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            chk("alt_p0", t0[i] - t0[0], i * (ACC + 1));
            chk("alt_p1", t1[i] - t0[0], (i + 3) * (ACC + 1));
`else
            chk("alt_p0", t0[i] - t0[0], 2 * i * (ACC + 1));
            chk("alt_p1", t1[i] - t0[0], (2 * i + 1) * (ACC + 1));
`endif
        end

        fork
            rand_port(0, 80);
            rand_port(1, 80);
        join
        repeat (8) @(negedge clk);

        issue(0, 0, 20'h00123, 16'h0, 2'b11, t);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ce_n", ce_n, 1);
        chk("ar_oe_n", oe_n, 1);
        chk("ar_we_n", we_n, 1);
        repeat (4) begin
            @(negedge clk);
            chk("ar_no_rvalid", rv0, 0);
        end
        rst_n = 1'b1;
        issue(1, 0, 20'h00123, 16'h0, 2'b11, t);
        repeat (ACC) @(negedge clk);
        chk("ar_p1_rvalid", rv1, 1);
        chk("ar_p1_rdata", rd1, 16'hA5C3);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
